// File: rtl/tone_synth.sv
// tone_synth: keyboard-driven square-wave tone generator.
// A PS/2 scan code selects one of seven notes, the octave input right-shifts
// the base half-period, and a free-running carrier PWM gates the tone for volume.
// Note/octave changes land only on half-period boundaries; a release tail keeps
// the tone sounding after key-up and always ends on a 1->0 toggle.
module tone_synth #(
    parameter int         CNT_W       = 20,
    parameter int         OCT_W       = 2,
    parameter int         VOL_W       = 3,
    parameter int         RELEASE_CYC = 5000000,
    parameter logic [7:0] MUTE_CODE   = 8'h05
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       scan,
    input  logic [OCT_W-1:0] octave,
    input  logic [VOL_W-1:0] volume,
    output logic             pwm_out,
    output logic [CNT_W-1:0] half_period,
    output logic             mute,
    output logic [1:0]       state
);

    localparam int REL_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_REL  = 2'b10
    } state_t;

    state_t           st;
    logic             tone;
    logic [CNT_W-1:0] cnt;
    logic [VOL_W-1:0] car;
    logic [REL_W-1:0] rel_cnt;

    logic             is_note;
    logic             is_mute;
    logic [31:0]      base;
    logic [CNT_W-1:0] period;
    logic             boundary;
    logic             gate;
    logic             tone_run;
    logic [CNT_W-1:0] cnt_run;
    logic [CNT_W-1:0] hp_run;

    assign state = st;

    // Scan-code decode to base half-period, then octave shift (truncating).
    always_comb begin
        is_note = 1'b1;
        base    = '0;
        case (scan)
            8'h23:   base = 32'd191116;
            8'h2D:   base = 32'd170264;
            8'h3A:   base = 32'd151689;
            8'h2B:   base = 32'd143172;
            8'h1B:   base = 32'd127551;
            8'h4B:   base = 32'd113636;
            8'h21:   base = 32'd101239;
            default: is_note = 1'b0;
        endcase
        period = CNT_W'(base >> octave);
    end

    // Next values of the tone oscillator when it simply keeps running; the
    // half-period reloads only at a boundary and only while a note is held.
    always_comb begin
        is_mute  = (scan == MUTE_CODE);
        boundary = (cnt == half_period - CNT_W'(1));
        gate     = (volume == '1) || (car < volume);
        tone_run = boundary ? ~tone : tone;
        cnt_run  = boundary ? '0 : cnt + 1'b1;
        hp_run   = (boundary && is_note) ? period : half_period;
    end

    // Control FSM, oscillator, release timer, carrier and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st          <= S_IDLE;
            tone        <= 1'b0;
            cnt         <= '0;
            half_period <= '0;
            car         <= '0;
            rel_cnt     <= '0;
            mute        <= 1'b0;
            pwm_out     <= 1'b0;
        end else begin
            mute    <= is_mute;
            car     <= car + 1'b1;
            pwm_out <= tone & gate;
            case (st)
                S_IDLE: begin
                    tone        <= 1'b0;
                    cnt         <= '0;
                    half_period <= '0;
                    if (is_note && !mute) begin
                        st          <= S_PLAY;
                        half_period <= period;
                    end
                end
                S_PLAY: begin
                    if (is_mute) begin
                        st          <= S_IDLE;
                        tone        <= 1'b0;
                        cnt         <= '0;
                        half_period <= '0;
                    end else begin
                        tone        <= tone_run;
                        cnt         <= cnt_run;
                        half_period <= hp_run;
                        if (!is_note) begin
                            st      <= S_REL;
                            rel_cnt <= REL_W'(RELEASE_CYC - 1);
                        end
                    end
                end
                S_REL: begin
                    // Mute beats everything, a new note beats expiry, and an
                    // expired tail waits for the high phase to finish.
                    if (is_mute || (!is_note && rel_cnt == '0 && (!tone || boundary))) begin
                        st          <= S_IDLE;
                        tone        <= 1'b0;
                        cnt         <= '0;
                        half_period <= '0;
                    end else begin
                        tone        <= tone_run;
                        cnt         <= cnt_run;
                        half_period <= hp_run;
                        if (is_note) begin
                            st <= S_PLAY;
                        end else if (rel_cnt != '0) begin
                            rel_cnt <= rel_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    st          <= S_IDLE;
                    tone        <= 1'b0;
                    cnt         <= '0;
                    half_period <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: randomized + directed stimulus against a behavioural model of
// tone_synth. The driver predicts each post-edge output and queues it; the
// monitor pops one expectation per clock and compares.
module tb_tone_synth;

    localparam int CNT_W = 20;
    localparam int OCT_W = 4;
    localparam int VOL_W = 3;
    localparam int REL   = 1000;

    typedef struct packed {
        logic             pwm;
        logic [CNT_W-1:0] hp;
        logic             mute;
        logic [1:0]       st;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       scan = 8'h00;
    logic [OCT_W-1:0] octave = '0;
    logic [VOL_W-1:0] volume = '0;
    logic             pwm_out;
    logic [CNT_W-1:0] half_period;
    logic             mute;
    logic [1:0]       state;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // Model: phase 0 idle / 1 play / 2 release; level is the square wave;
    // left counts cycles remaining in the current half-cycle.
    int m_phase = 0, m_level = 0, m_left = 0, m_hp = 0, m_tail = 0;
    int m_car = 0, m_mute = 0, m_pwm = 0;

    logic [7:0] notes [7] = '{8'h23, 8'h2D, 8'h3A, 8'h2B, 8'h1B, 8'h4B, 8'h21};

    tone_synth #(
        .CNT_W(CNT_W),
        .OCT_W(OCT_W),
        .VOL_W(VOL_W),
        .RELEASE_CYC(REL),
        .MUTE_CODE(8'h05)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .scan(scan),
        .octave(octave),
        .volume(volume),
        .pwm_out(pwm_out),
        .half_period(half_period),
        .mute(mute),
        .state(state)
    );

    always #5 clk = ~clk;

    function automatic int base_of(input logic [7:0] sc);
        case (sc)
            8'h23:   return 191116;
            8'h2D:   return 170264;
            8'h3A:   return 151689;
            8'h2B:   return 143172;
            8'h1B:   return 127551;
            8'h4B:   return 113636;
            8'h21:   return 101239;
            default: return 0;
        endcase
    endfunction

    task automatic go_silent();
        m_phase = 0;
        m_level = 0;
        m_hp    = 0;
        m_left  = 0;
    endtask

    // Predict the outputs after the coming rising edge from current inputs.
    task automatic step();
        int   b, per, pwm_n;
        bit   valid, bnd;
        int   old_level;
        exp_t e;
        old_level = m_level;
        if (!rst_n) begin
            go_silent();
            m_tail = 0; m_car = 0; m_mute = 0; m_pwm = 0;
        end else begin
            b     = base_of(scan);
            valid = (b != 0);
            per   = (b >> octave) % (1 << CNT_W);
            pwm_n = (m_level != 0 && (volume == 3'd7 || m_car < int'(volume))) ? 1 : 0;
            bnd   = (m_left == 1);
            if (m_phase == 0) begin
                if (valid && m_mute == 0) begin
                    m_phase = 1; m_hp = per; m_left = per; m_level = 0;
                end
            end else if (scan == 8'h05) begin
                go_silent();
            end else if (m_phase == 2 && !valid && m_tail == 0 && (old_level == 0 || bnd)) begin
                go_silent();
            end else begin
                if (bnd) begin
                    m_level = 1 - m_level;
                    if (valid) m_hp = per;
                    m_left = m_hp;
                end else begin
                    m_left = m_left - 1;
                end
                if (m_phase == 1 && !valid) begin
                    m_phase = 2;
                    m_tail  = REL - 1;
                end else if (m_phase == 2) begin
                    if (valid) m_phase = 1;
                    else if (m_tail > 0) m_tail = m_tail - 1;
                end
            end
            m_pwm  = pwm_n;
            m_mute = (scan == 8'h05) ? 1 : 0;
            m_car  = (m_car + 1) % (1 << VOL_W);
        end
        e.pwm  = m_pwm[0];
        e.hp   = CNT_W'(m_hp);
        e.mute = m_mute[0];
        e.st   = 2'(m_phase);
        q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic [7:0] s, input int o, input int v, input int n);
        repeat (n) begin
            @(negedge clk);
            rst_n  = r;
            scan   = s;
            octave = OCT_W'(o);
            volume = VOL_W'(v);
            step();
        end
    endtask

    // Monitor: the DUT presents a new output every clock.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total += 4;
                if (state !== e.st) begin
                    bad++;
                    $display("FAIL state t=%0t got=%0d want=%0d", $time, state, e.st);
                end
                if (half_period !== e.hp) begin
                    bad++;
                    $display("FAIL half_period t=%0t got=%0d want=%0d", $time, half_period, e.hp);
                end
                if (mute !== e.mute) begin
                    bad++;
                    $display("FAIL mute t=%0t got=%0d want=%0d", $time, mute, e.mute);
                end
                if (pwm_out !== e.pwm) begin
                    bad++;
                    $display("FAIL pwm_out t=%0t got=%0d want=%0d", $time, pwm_out, e.pwm);
                end
            end
        end
    end

    initial begin
        int r;
        // reset, then base-octave note entry and mute
        cyc(1'b0, 8'h00, 0, 7, 3);
        cyc(1'b1, 8'h23, 0, 7, 5);
        cyc(1'b1, 8'h05, 0, 7, 3);
        cyc(1'b1, 8'h00, 0, 7, 3);
        // note change mid-half-cycle
        cyc(1'b1, 8'h23, 10, 7, 300);
        cyc(1'b1, 8'h21, 10, 7, 400);
        // octave change while held: 14204 -> 56818 at next toggle
        cyc(1'b1, 8'h4B, 3, 7, 100);
        cyc(1'b1, 8'h4B, 1, 7, 14300);
        cyc(1'b1, 8'h05, 1, 7, 3);
        cyc(1'b1, 8'h00, 1, 7, 2);
        // release tail
        cyc(1'b1, 8'h2D, 9, 7, 500);
        cyc(1'b1, 8'h00, 9, 7, 1800);
        // volume gating then mute
        cyc(1'b1, 8'h3A, 9, 2, 800);
        cyc(1'b1, 8'h3A, 9, 0, 300);
        cyc(1'b1, 8'h05, 9, 0, 5);
        cyc(1'b1, 8'h00, 9, 5, 2);
        // reset mid-note and during release
        cyc(1'b1, 8'h1B, 10, 7, 200);
        cyc(1'b0, 8'h1B, 10, 7, 2);
        cyc(1'b1, 8'h1B, 10, 7, 150);
        cyc(1'b1, 8'h00, 10, 7, 300);
        cyc(1'b0, 8'h00, 10, 7, 2);
        // randomized segments
        for (int i = 0; i < 40; i++) begin
            logic [7:0] s;
            r = $urandom_range(0, 9);
            if (r < 7) s = notes[r];
            else if (r == 7) s = 8'h00;
            else if (r == 8) s = 8'h05;
            else s = 8'($urandom);
            if ($urandom_range(0, 19) == 0) cyc(1'b0, s, 10, 7, 2);
            cyc(1'b1, s, $urandom_range(8, 12), $urandom_range(0, 7), $urandom_range(50, 1200));
        end
        @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
